// File: rtl/counter_ctrl.sv
// counter_ctrl: control/configuration sequencer for the interval counter.
//
// It owns the counter's state code (0 = RESET, 1 = RUN, 2 = HALT), the
// 32-bit interval setting and a target-count register. Start/stop/clear
// commands arrive over a valid/ready handshake. When the counter reaches a
// non-zero target, the sequencer halts it automatically.
//
// Optional feature, build macro COUNTER_CTRL_AUTO_RELOAD_EN:
//   When defined, a target hit enters a clear window of CLR_CYCLES cycles
//   and then returns straight to RUN instead of HALT. reload_cnt counts
//   these hits. When undefined, reload_cnt is tied to 0.
//
// Ports:
//   clk        : system clock; all logic on posedge
//   rst        : asynchronous, active-high reset
//   cmd_valid  : command present
//   cmd_ready  : command accepted when cmd_valid && cmd_ready (low in CLR)
//   cmd_op     : 0=NOP 1=START 2=STOP 3=CLEAR
//   cfg_we     : config write strobe (single cycle)
//   cfg_addr   : 0=interval 1=target
//   cfg_wdata  : config write data
//   cfg_err    : one-cycle pulse, write rejected because the FSM was in RUN
//   counter_in : current count from the counter datapath
//   state      : state code driven to the counter
//   interval   : interval driven to the counter (never 0)
//   done       : one-cycle pulse after a target hit
//   busy       : high while the state is RUN
//   reload_cnt : number of auto-reload hits (wraps at 16 bits)
module counter_ctrl #(
  parameter logic [31:0] DEFAULT_INTERVAL = 32'd1,
  parameter int          CLR_CYCLES       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cfg_we,
  input  logic        cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_err,
  input  logic [31:0] counter_in,
  output logic [7:0]  state,
  output logic [31:0] interval,
  output logic        done,
  output logic        busy,
  output logic [15:0] reload_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_CLR  = 2'd3
  } fsm_t;

  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // The down-counter runs from CLR_CYCLES-1 to 0, so CLR lasts exactly CLR_CYCLES cycles.
  localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES - 1);

  fsm_t        fsm, fsm_nxt;
  logic [7:0]  clr_cnt, clr_cnt_nxt;
  logic        clr_to_run, clr_to_run_nxt;  // CLR window belongs to an auto-reload
  logic [31:0] target;
  logic        done_nxt;
  logic        accept;
  logic        hit;

  // Map an FSM state to the code seen by the counter.
  function automatic logic [7:0] code_of(input fsm_t s);
    case (s)
      S_RUN:   code_of = 8'd1;
      S_HALT:  code_of = 8'd2;
      default: code_of = 8'd0;  // IDLE and CLR both present RESET
    endcase
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign hit    = (target != 32'd0) && (counter_in >= target);

  // Next-state logic. Priority is CLEAR > target hit > STOP > START.
  always_comb begin
    fsm_nxt        = fsm;
    clr_cnt_nxt    = clr_cnt;
    clr_to_run_nxt = clr_to_run;
    done_nxt       = 1'b0;
    case (fsm)
      S_IDLE: begin
        if (accept && cmd_op == OP_CLEAR) begin
          fsm_nxt        = S_CLR;
          clr_cnt_nxt    = CLR_LOAD;
          clr_to_run_nxt = 1'b0;
        end else if (accept && cmd_op == OP_START) begin
          fsm_nxt = S_RUN;
        end else begin
          fsm_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept && cmd_op == OP_CLEAR) begin
          // A clear that coincides with a hit suppresses done.
          fsm_nxt        = S_CLR;
          clr_cnt_nxt    = CLR_LOAD;
          clr_to_run_nxt = 1'b0;
        end else if (hit) begin
          done_nxt = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
          fsm_nxt        = S_CLR;
          clr_cnt_nxt    = CLR_LOAD;
          clr_to_run_nxt = 1'b1;
`else
          fsm_nxt = S_HALT;
`endif
        end else if (accept && cmd_op == OP_STOP) begin
          fsm_nxt = S_HALT;
        end else begin
          fsm_nxt = S_RUN;
        end
      end
      S_HALT: begin
        if (accept && cmd_op == OP_CLEAR) begin
          fsm_nxt        = S_CLR;
          clr_cnt_nxt    = CLR_LOAD;
          clr_to_run_nxt = 1'b0;
        end else if (accept && cmd_op == OP_START) begin
          fsm_nxt = S_RUN;
        end else begin
          fsm_nxt = S_HALT;
        end
      end
      S_CLR: begin
        if (clr_cnt == 8'd0) begin
          fsm_nxt = clr_to_run ? S_RUN : S_IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt - 8'd1;
        end
      end
      default: begin
        fsm_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs. The outputs follow fsm_nxt so that they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= S_IDLE;
      clr_cnt    <= 8'd0;
      clr_to_run <= 1'b0;
      state      <= 8'd0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      interval   <= DEFAULT_INTERVAL;
      target     <= 32'd0;
    end else begin
      fsm        <= fsm_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clr_to_run <= clr_to_run_nxt;
      state      <= code_of(fsm_nxt);
      busy       <= (fsm_nxt == S_RUN);
      cmd_ready  <= (fsm_nxt != S_CLR);
      done       <= done_nxt;
      // Reject a config write only when the FSM is in RUN at this edge.
      // This means a write that coincides with START is still accepted.
      cfg_err    <= cfg_we && (fsm == S_RUN);
      if (cfg_we && fsm != S_RUN) begin
        if (cfg_addr == 1'b0) begin
          interval <= (cfg_wdata == 32'd0) ? 32'd1 : cfg_wdata;
        end else begin
          target <= cfg_wdata;
        end
      end
    end
  end

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  logic [15:0] reload_q;

  // Count the auto-reload hits; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= 16'd0;
    end else if (fsm == S_RUN && fsm_nxt == S_CLR && clr_to_run_nxt) begin
      reload_q <= reload_q + 16'd1;
    end
  end

  assign reload_cnt = reload_q;
`else
  assign reload_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Table-driven testbench for counter_ctrl.
// Each vector drives the inputs for one clock cycle. At the same time, the
// expected outputs are pushed onto a scoreboard queue. After the edge, one
// entry is popped and compared with what the design produced.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cfg_we;
  logic        cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_err;
  logic [31:0] counter_in;
  logic [7:0]  state;
  logic [31:0] interval;
  logic        done;
  logic        busy;
  logic [15:0] reload_cnt;

  localparam logic [1:0] NOP   = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic        we;
    logic        addr;
    logic [31:0] wd;
    logic [31:0] cin;
    logic [7:0]  st;
    logic        bsy;
    logic        rdy;
    logic        dn;
    logic        err;
    logic [31:0] intv;
    logic [15:0] rl;
  } vec_t;

  typedef struct {
    int          idx;
    logic [7:0]  st;
    logic        bsy;
    logic        rdy;
    logic        dn;
    logic        err;
    logic [31:0] intv;
    logic [15:0] rl;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  counter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_err    (cfg_err),
    .counter_in (counter_in),
    .state      (state),
    .interval   (interval),
    .done       (done),
    .busy       (busy),
    .reload_cnt (reload_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic cv, input logic [1:0] op, input logic we,
                             input logic addr, input logic [31:0] wd, input logic [31:0] cin,
                             input logic [7:0] st, input logic bsy, input logic rdy,
                             input logic dn, input logic err, input logic [31:0] intv,
                             input logic [15:0] rl);
    vec_t r;
    r.cv = cv; r.op = op; r.we = we; r.addr = addr; r.wd = wd; r.cin = cin;
    r.st = st; r.bsy = bsy; r.rdy = rdy; r.dn = dn; r.err = err; r.intv = intv; r.rl = rl;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_values(input int idx);
    check("rst_state", idx, 32'(state), 32'd0);
    check("rst_busy", idx, 32'(busy), 32'd0);
    check("rst_ready", idx, 32'(cmd_ready), 32'd1);
    check("rst_done", idx, 32'(done), 32'd0);
    check("rst_cfg_err", idx, 32'(cfg_err), 32'd0);
    check("rst_interval", idx, interval, 32'd1);
    check("rst_reload", idx, 32'(reload_cnt), 32'd0);
  endtask

  task automatic apply(input int idx, input vec_t x);
    exp_t e;
    cmd_valid  = x.cv;
    cmd_op     = x.op;
    cfg_we     = x.we;
    cfg_addr   = x.addr;
    cfg_wdata  = x.wd;
    counter_in = x.cin;
    e.idx = idx; e.st = x.st; e.bsy = x.bsy; e.rdy = x.rdy; e.dn = x.dn;
    e.err = x.err; e.intv = x.intv; e.rl = x.rl;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("state", e.idx, 32'(state), 32'(e.st));
    check("busy", e.idx, 32'(busy), 32'(e.bsy));
    check("cmd_ready", e.idx, 32'(cmd_ready), 32'(e.rdy));
    check("done", e.idx, 32'(done), 32'(e.dn));
    check("cfg_err", e.idx, 32'(cfg_err), 32'(e.err));
    check("interval", e.idx, interval, e.intv);
    check("reload_cnt", e.idx, 32'(reload_cnt), 32'(e.rl));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cfg_we = 1'b0; cfg_addr = 1'b0;
    cfg_wdata = 32'd0; counter_in = 32'd0;

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    // Auto-reload: target 4 with three hits; each hit is followed by a
    // two-cycle clear window, then the FSM returns to RUN.
    tbl.push_back(v(1'b0, NOP, 1'b1, 1'b1, 32'd4, 32'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0, 32'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    for (int k = 1; k <= 3; k++) begin
      tbl.push_back(v(1'b0, NOP, 1'b0, 1'b0, 32'd0, 32'd4, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 16'(k)));
      tbl.push_back(v(1'b0, NOP, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'(k)));
      tbl.push_back(v(1'b0, NOP, 1'b0, 1'b0, 32'd0, 32'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'(k)));
      tbl.push_back(v(1'b0, NOP, 1'b0, 1'b0, 32'd0, 32'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'(k)));
    end
`else
    //                cv    op     we    addr   wdata         cin           st    bsy   rdy   done  err   intv    rl
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b0, 32'd3,   32'd0,        8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b1, 32'd5,   32'd0,        8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd0,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd4,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd5,        8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd6,        8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b1, 32'd100, 32'd6,        8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd6,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b0, 32'd7,   32'd7,        8'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd8,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, STOP,  1'b0, 1'b0, 32'd0,   32'd9,        8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd9,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, STOP,  1'b0, 1'b0, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, CLEAR, 1'b0, 1'b0, 32'd0,   32'd10,       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd10,       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd10,       8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd10,       8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b1, STOP,  1'b0, 1'b0, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b0, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b1, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'hFFFFFFFF, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'hFFFFFFFF, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'hFFFFFFFF, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, STOP,  1'b0, 1'b0, 32'd0,   32'd0,        8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b1, 32'd10,  32'd0,        8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd0,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, STOP,  1'b0, 1'b0, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd10,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd10,       8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, CLEAR, 1'b0, 1'b0, 32'd0,   32'd10,       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd10,       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd0,        8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b1, 1'b1, 32'd50,  32'd0,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd49,       8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b0, 1'b0, 32'd0,   32'd50,       8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 16'd0));
    tbl.push_back(v(1'b0, NOP,   1'b1, 1'b0, 32'd9,   32'd50,       8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 16'd0));
    tbl.push_back(v(1'b1, START, 1'b0, 1'b0, 32'd0,   32'd0,        8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 16'd0));
`endif

    // Reset values while rst is held.
    #12;
    check_reset_values(-1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end

    // The table ends in RUN. An asynchronous reset between edges must
    // return the outputs to their reset values without a clock edge.
    cmd_valid = 1'b0;
    cfg_we    = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_values(-2);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Control/configuration sequencer for the interval counter datapath. Owns the counter's 8-bit state code (RESET=0, RUN=1, HALT=2), its 32-bit interval setting and a target-count register. Accepts start/stop/clear commands over a valid/ready handshake and auto-halts the counter on reaching the target. Sits between the host-side control registers and the counter instance.

Parameters:
DEFAULT_INTERVAL, 32'd1, interval value loaded on reset
CLR_CYCLES, 2, cycles state code RESET is held during a clear (1..255)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0=NOP, 1=START, 2=STOP, 3=CLEAR
cfg_we  input  1  config write strobe, single cycle
cfg_addr  input  1  0=interval, 1=target
cfg_wdata  input  32  config write data
cfg_err  output  1  one-cycle pulse: write rejected
counter_in  input  32  current count from counter datapath
state  output  8  state code driven to counter
interval  output  32  interval driven to counter
done  output  1  one-cycle pulse on target hit
busy  output  1  high while state==RUN
reload_cnt  output  16  auto-reload count (see Optional Feature)

Behaviour:
- Reset (async, rst=1): FSM=IDLE, state=0, interval=DEFAULT_INTERVAL, target=0, done=0, cfg_err=0, busy=0, reload_cnt=0, cmd_ready=1. rst mid-run aborts immediately; no done.
- FSM states and state code: IDLE->0, RUN->1, HALT->2, CLR->0. state, busy and cmd_ready are registered, updating on the same edge as the FSM.
- Command accepted on the edge where cmd_valid && cmd_ready. New state is visible after that edge (latency 1 cycle).
- cmd_ready = 0 in CLR, 1 otherwise.
- IDLE: START->RUN; CLEAR->CLR; STOP/NOP ignored.
- RUN: STOP->HALT; CLEAR->CLR; START ignored.
- HALT: START->RUN (resume, count preserved); CLEAR->CLR; STOP ignored.
- CLR: hold code 0 for exactly CLR_CYCLES cycles (internal 8-bit down-counter), then ->IDLE.
- Target hit: in RUN, target!=0 and counter_in>=target (unsigned) sampled at an edge -> HALT at that edge, with done=1 for the following cycle. target==0 disables auto-halt.
- Overshoot: with interval==1, the counter may have incremented once more on the hit edge, so the final count is target+1. This is accepted and deterministic.
- Simultaneous events, priority: rst > CLEAR > target hit > STOP > START.
  - STOP coincident with hit: HALT, done pulses.
  - CLEAR coincident with hit: CLR, no done.
- Config writes:
  - Accepted in IDLE, HALT and CLR.
  - In RUN: ignored, with cfg_err=1 for one cycle.
  - Writing interval=0 stores 1.
  - New values take effect on the next edge.
  - cfg_we coincident with a START command: the write is accepted (FSM not yet RUN).
- done and cfg_err default to 0 every cycle unless set as above.

Optional Feature:
Macro: COUNTER_CTRL_AUTO_RELOAD_EN.
- Defined: on target hit, go RUN->CLR for CLR_CYCLES, then directly to RUN (not IDLE). done still pulses. reload_cnt increments per hit and wraps 0xFFFF->0. STOP/CLEAR during the reload CLR are not accepted (cmd_ready=0). A CLEAR command's CLR returns to IDLE as normal.
- Undefined: hit ->HALT as above; reload_cnt tied to 0.

Test Plan:
- Reset; write interval=3, target=5; START -> state=1 next cycle. When counter_in=5 is sampled, state=2 next cycle, done high exactly one cycle, busy falls.
- RUN, then STOP, START -> state 1->2->1; count from counter_in not cleared. Write during RUN -> cfg_err one cycle, interval unchanged.
- CLEAR from HALT with CLR_CYCLES=2 -> state=0 for 2 cycles with cmd_ready=0, then IDLE. START held valid meanwhile is accepted only on the first ready cycle.
- Write interval=0 -> interval output reads 1. target=0 with counter_in=0xFFFFFFFF -> no halt.
- STOP and target hit on the same edge -> HALT with done=1. CLEAR and hit together -> state=0, no done. Assert rst mid-RUN -> outputs at reset values immediately, asynchronously.
- With COUNTER_CTRL_AUTO_RELOAD_EN, target=4: three hits -> three done pulses, each followed by a CLR_CYCLES window of state 0 and return to RUN; reload_cnt=3.
